// File: rtl/mult_share_pkg.sv
// Shared constants and FSM state type for the multiplier-sharing controller.
// The multiplier is 11x8 signed with a fixed 8-cycle latency and a 19-bit result.
package mult_share_pkg;

  localparam int MUL_LAT = 8;
  localparam int N1_W    = 11;
  localparam int N2_W    = 8;
  localparam int RES_W   = 19;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_tag_pipe.sv
// LAT-deep {valid, id} delay line that shadows the shared multiplier pipeline.
// Both fields are cleared on reset so in-flight products are never reported.
module mult_tag_pipe #(
  parameter int LAT = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  input  logic [IDW-1:0] in_id,
  output logic           out_vld,
  output logic [IDW-1:0] out_id
);

  logic [LAT-1:0] vld_p;
  logic [IDW-1:0] id_p [LAT];

  // stage 0 captures the issue; stage LAT-1 lines up with the multiplier result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < LAT; i++) id_p[i] <= '0;
    end else begin
      vld_p   <= {vld_p[LAT-2:0], in_vld};
      id_p[0] <= in_id;
      for (int i = 1; i < LAT; i++) id_p[i] <= id_p[i-1];
    end
  end

  assign out_vld = vld_p[LAT-1];
  assign out_id  = id_p[LAT-1];

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one pipelined 11x8 signed multiplier among NREQ
// requesters, with result tagging and a drain handshake for quiescing.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = MUL_LAT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N1_W-1:0]     a_in,
  input  logic [NREQ*N2_W-1:0]     b_in,
  output logic [NREQ-1:0]          gnt,
  output logic signed [N1_W-1:0]   mul_n1,
  output logic signed [N2_W-1:0]   mul_n2,
  input  logic signed [RES_W-1:0]  mul_result,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic signed [RES_W-1:0]  rsp_result,
  input  logic                     drain_req,
  output logic                     drained,
  output logic [3:0]               inflight
);

  state_e         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           issue;
  logic [3:0]     inflight_nxt;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NREQ-1)) ? '0 : p + 1'b1;
  endfunction

  // Rotating-priority search starting at rr_ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = ptr_inc(idx);
    end
  end

  // Reset also blocks issue so nothing enters the multiplier while held in reset
  assign issue = rst_n && found && (state == RUN) && !drain_req;

  // Grant and operand mux for the issue cycle; operands are zero otherwise
  always_comb begin
    gnt    = '0;
    mul_n1 = '0;
    mul_n2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (win == IDW'(i))) begin
        gnt[i] = 1'b1;
        mul_n1 = a_in[N1_W*i +: N1_W];
        mul_n2 = b_in[N2_W*i +: N2_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_ptr <= '0;
    else if (issue) rr_ptr <= ptr_inc(win);
  end

  always_comb begin
    case ({issue, rsp_valid})
      2'b10:   inflight_nxt = inflight + 4'd1;
      2'b01:   inflight_nxt = inflight - 4'd1;
      default: inflight_nxt = inflight;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else        inflight <= inflight_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_req) state <= DRAIN;
        end
        DRAIN: begin
          if ((inflight == 4'd0) || (inflight_nxt == 4'd0)) begin
            state   <= HALT;
            drained <= 1'b1;
          end
        end
        HALT: begin
          if (!drain_req) begin
            state   <= RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

  // Tag delay line runs in lockstep with the external multiplier
  mult_tag_pipe #(
    .LAT (LAT),
    .IDW (IDW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (issue),
    .in_id   (win),
    .out_vld (rsp_valid),
    .out_id  (rsp_id)
  );

  assign rsp_result = rsp_valid ? mul_result : '0;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with an 8-stage signed multiplier stand-in.
module tb_mult_share_ctrl;
  import mult_share_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*N1_W-1:0]    a_in;
  logic [NREQ*N2_W-1:0]    b_in;
  logic [NREQ-1:0]         gnt;
  logic signed [N1_W-1:0]  mul_n1;
  logic signed [N2_W-1:0]  mul_n2;
  logic signed [RES_W-1:0] mul_result;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic signed [RES_W-1:0] rsp_result;
  logic                    drain_req;
  logic                    drained;
  logic [3:0]              inflight;

  int n_checks = 0;
  int n_fails  = 0;

  int ea [4] = '{100, -1024, 1023, -7};
  int eb [4] = '{-2, -128, 127, 9};
  int ep [4] = '{-200, 131072, 129921, -63};

  always #5 clk = ~clk;

  // Shared multiplier: operands registered through MUL_LAT stages, no reset
  logic signed [RES_W-1:0] mul_pipe [MUL_LAT];
  always_ff @(posedge clk) begin
    mul_pipe[0] <= RES_W'(mul_n1) * RES_W'(mul_n2);
    for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  mult_share_ctrl #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .mul_n1     (mul_n1),
    .mul_n2     (mul_n2),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .drain_req  (drain_req),
    .drained    (drained),
    .inflight   (inflight)
  );

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[N1_W*i +: N1_W] = N1_W'(a);
    b_in[N2_W*i +: N2_W] = N2_W'(b);
  endtask

  initial begin
    int nrsp;
    int waited;
    logic [NREQ-1:0] gnt_seen;

    rst_n = 1'b0; req = 4'b0001; a_in = '0; b_in = '0; drain_req = 1'b0;
    set_op(0, 3, 3);
    settle();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_result", rsp_result, 19'd0);
    chk("rst_drained", drained, 1'b0);
    chk("rst_inflight", inflight, 4'd0);
    chk("rst_mul_n1", mul_n1, 0);
    chk("rst_mul_n2", mul_n2, 0);
    tick(); rst_n = 1'b1; req = '0; a_in = '0;
    tick(); tick();

    // Single request, exact latency
    tick(); req = 4'b0100; set_op(2, -5, 3);
    settle();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_n1", mul_n1, -5);
    chk("single_n2", mul_n2, 3);
    for (int k = 1; k <= 8; k++) begin
      tick(); req = '0;
      settle();
      if (k == 1) chk("single_inflight1", inflight, 4'd1);
      if (k == 1) chk("idle_n1_zero", mul_n1, 0);
      if (k == 7) chk("single_early_valid", rsp_valid, 1'b0);
      if (k == 8) begin
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_id", rsp_id, 2'd2);
        chk("single_result", rsp_result, 19'h7FFF1);
      end
    end
    tick(); settle();
    chk("single_after_valid", rsp_valid, 1'b0);
    chk("single_after_inflight", inflight, 4'd0);

    // Zero operand from requester 3 (also moves rr_ptr back to 0)
    tick(); req = 4'b1000; set_op(3, 0, -128);
    settle();
    chk("zero_gnt", gnt, 4'b1000);
    for (int k = 1; k <= 8; k++) begin
      tick(); req = '0;
      settle();
    end
    chk("zero_valid", rsp_valid, 1'b1);
    chk("zero_id", rsp_id, 2'd3);
    chk("zero_result", rsp_result, 19'd0);
    tick();

    // All four held: round-robin order and back-to-back responses
    for (int i = 0; i < 4; i++) set_op(i, ea[i], eb[i]);
    for (int k = 0; k < 16; k++) begin
      tick(); req = (k < 8) ? 4'hF : 4'h0;
      settle();
      if (k < 8) begin
        chk("rr_gnt", gnt, 4'b0001 << (k % 4));
        chk("rr_n1", mul_n1, ea[k % 4]);
      end else begin
        if (k == 8) chk("rr_inflight_max", inflight, 4'd8);
        chk("rr_valid", rsp_valid, 1'b1);
        chk("rr_id", rsp_id, k % 4);
        chk("rr_result", rsp_result, ep[k % 4]);
      end
    end
    tick(); settle();
    chk("rr_inflight_end", inflight, 4'd0);

    // Drain after five issues
    for (int k = 0; k < 5; k++) begin
      tick(); req = 4'hF;
      settle();
      chk("pre_drain_gnt", gnt, 4'b0001 << (k % 4));
    end
    tick(); drain_req = 1'b1;
    settle();
    chk("drain_no_gnt", gnt, 4'b0000);
    chk("drain_n1_zero", mul_n1, 0);
    nrsp = 0; gnt_seen = '0;
    for (int k = 1; k <= 9; k++) begin
      tick(); settle();
      gnt_seen = gnt_seen | gnt;
      if (rsp_valid) begin
        chk("drain_rsp_id", rsp_id, nrsp % 4);
        nrsp++;
      end
      if (k == 7) chk("drain_not_yet", drained, 1'b0);
      if (k == 8) begin
        chk("drained_set", drained, 1'b1);
        chk("drained_inflight", inflight, 4'd0);
      end
    end
    chk("drain_rsp_count", nrsp, 5);
    chk("drain_gnt_seen", gnt_seen, 4'b0000);
    tick(); drain_req = 1'b0;
    settle();
    chk("release_drained_hold", drained, 1'b1);
    chk("release_gnt_hold", gnt, 4'b0000);
    tick(); settle();
    chk("release_drained_fall", drained, 1'b0);
    chk("release_gnt", gnt, 4'b0010);

    // Reset with six operations in flight
    for (int k = 0; k < 5; k++) begin
      tick(); req = 4'hF;
      settle();
    end
    chk("mid_inflight", inflight, 4'd5);
    tick(); req = '0; rst_n = 1'b0;
    settle();
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_id", rsp_id, 2'd0);
    chk("mid_rst_result", rsp_result, 19'd0);
    chk("mid_rst_inflight", inflight, 4'd0);
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_drained", drained, 1'b0);
    tick(); rst_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (rsp_valid) nrsp++;
      tick();
    end
    chk("mid_rst_no_rsp", nrsp, 0);
    chk("mid_rst_inflight_after", inflight, 4'd0);

    // Fairness: req[0] constant, req[3] pulsed until granted
    req = 4'b0001;
    settle();
    chk("fair_gnt0", gnt, 4'b0001);
    tick(); settle();
    tick(); req = 4'b1001;
    settle();
    waited = 0;
    while (!gnt[3] && waited < 4) begin
      tick(); settle();
      waited++;
    end
    chk("fair_gnt3", gnt[3], 1'b1);
    chk("fair_wait_bound", waited < 4, 1'b1);
    tick(); req = 4'b0001;
    settle();
    chk("fair_back_to_0", gnt, 4'b0001);
    tick(); req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Round-robin scheduler that shares the single 11x8 signed pipelined multiplier (fixed 8-cycle latency, no stall, no reset) among NREQ requesters. Issues at most one operation per cycle and tags it with the requester ID. Tracks the operation through a valid/ID delay line that matches the multiplier latency, then broadcasts the tagged result. Provides a drain handshake so upstream logic can quiesce the multiplier before reconfiguring or switching modes.

## Interface
- NREQ, 4: number of requesters (2..8)
- LAT, 8: multiplier latency in cycles, from operand presentation to result register
- IDW, $clog2(NREQ): width of the requester ID
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req  in  NREQ  per-requester request; held with operands stable until granted
- a_in  in  NREQ*11  per-requester signed multiplicand, slice i = [11*i+10:11*i]
- b_in  in  NREQ*8  per-requester signed multiplier, slice i = [8*i+7:8*i]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as req
- mul_n1  out  11  operand to multiplier n1
- mul_n2  out  8  operand to multiplier n2
- mul_result  in  19  multiplier result
- rsp_valid  out  1  result valid; one cycle per issued operation
- rsp_id  out  IDW  requester index owning the result
- rsp_result  out  19  signed product; 0 when rsp_valid=0
- drain_req  in  1  stop issuing and empty the pipeline
- drained  out  1  pipeline empty while in HALT
- inflight  out  4  count of operations in flight, 0..LAT

## Operation
- FSM states are RUN, DRAIN and HALT. Reset state is RUN.
- Transitions:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> HALT when inflight=0, or when the next cycle's count is 0.
  - HALT -> RUN when drain_req=0.
- Granting happens only in RUN with drain_req=0. The winner is the first asserted req at or after rr_ptr, searching upward modulo NREQ.
- When a grant is made (issue), rr_ptr <= winner+1 mod NREQ. Otherwise rr_ptr holds. rr_ptr resets to 0.
- In the issue cycle, mul_n1/mul_n2 = the winner's a_in/b_in slice. In any non-issue cycle they are 0.
- Delay line: LAT stages of {valid, id}. Stage 0 loads {issue, winner}. rsp_valid/rsp_id come from stage LAT-1.
- inflight is incremented by issue and decremented by rsp_valid. Both in the same cycle leaves it unchanged. Max value is LAT.
- Responses cannot be back-pressured; requesters must accept rsp_valid in the cycle it is asserted.
- Arithmetic and sign are handled entirely by the multiplier. The controller only routes the 19-bit value.

## Timing
- Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_result=0, drained=0, inflight=0, mul_n1=0, mul_n2=0.
- Latency: an issue in cycle T gives rsp_valid=1 in cycle T+LAT (the 8th rising edge after T), with the product of the operands presented in T.
- Throughput: one issue per cycle. Back-to-back issues give back-to-back responses in the same order.
- Simultaneous req from several requesters: a single grant, chosen by rotating priority. Every continuously requesting source is granted within NREQ cycles.
- drain_req asserted in cycle T: no grant in cycle T. In-flight operations still complete and respond.
- drained=1 only in HALT. It falls in the first cycle after drain_req deasserts, which is also the first cycle granting is allowed again.
- Reset mid-operation clears the delay line, so in-flight products are discarded and never reported. The multiplier's internal registers are not reset; its output is masked by valid=0.
- A request arriving while in DRAIN or HALT stays pending and is not granted until RUN.

## Structure
- Shared package mult_share_pkg holds MUL_LAT=8, N1_W=11, N2_W=8, RES_W=19 and the FSM state enum {RUN, DRAIN, HALT}.
- Sub-module mult_tag_pipe: a parameterised LAT-deep {valid, id} shift register with async active-low clear.
- The top level contains the round-robin picker, operand mux, FSM and inflight counter. It instantiates the multiplier alongside this block, not inside it.

## Test plan
- Single request: req[2] with a=-5, b=3 in cycle 10 -> gnt=0100 in cycle 10; rsp_valid, rsp_id=2, rsp_result=-15 (19'h7FFF1) in cycle 18.
- All four req held for 8 cycles, rr_ptr=0 -> grants in order 0,1,2,3,0,1,2,3; eight consecutive responses with matching IDs and products.
- Zero operand: a=0, b=-128 -> rsp_result=0. Extremes: a=-1024, b=-128 -> rsp_result=131072.
- Drain: 5 issues, then drain_req=1 -> no gnt; 5 responses still arrive; drained=1 once inflight=0. Release drain_req -> pending req granted in the next cycle.
- Reset mid-stream: rst_n low for 1 cycle with 6 operations in flight -> no rsp_valid in the following 8 cycles; all outputs at reset values; inflight=0.
- Fairness: req[0] held constantly, req[3] pulsed -> req[3] is granted within 4 cycles of asserting.
